// File: rtl/pipe_control.sv
// Pipeline hazard controller: stalls, bubbles, CC enable, halt FSM and perf counters.
// Latency: stall/bubble/set_cc combinational from inputs; status, halt and counters update on clk.
// Backpressure: stalls upstream stages on load-use and ret hazards; freezes everything once halted.
module pipe_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  M_icode,
  input  logic [3:0]  W_icode,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  E_dstM,
  input  logic        e_Cnd,
  input  logic [2:0]  m_stat,
  input  logic [2:0]  W_stat,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall,
  output logic        set_cc,
  output logic [2:0]  cpu_stat,
  output logic        halted,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
  output logic [31:0] stall_cnt
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t state;
  logic   load_use;
  logic   mispredict;
  logic   ret_hz;
  logic   m_ok;
  logic   w_ok;

  // Hazard detection; a destination of F never matches, so an F source can never match either.
  always_comb begin
    m_ok       = (m_stat == STAT_AOK);
    w_ok       = (W_stat == STAT_AOK);
    load_use   = ((E_icode == I_MRMOV) || (E_icode == I_POP)) && (E_dstM != REG_NONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mispredict = (E_icode == I_JXX) && !e_Cnd;
    ret_hz     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  end

  // Pipeline register controls: quiet under reset, frozen stages when halted, hazard logic in RUN.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    set_cc   = 1'b0;
    if (rst) begin
      F_stall = 1'b0;
    end else if (state == HALTED) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      F_stall  = load_use | ret_hz;
      D_stall  = load_use;
      D_bubble = mispredict | (ret_hz & ~load_use);
      E_bubble = mispredict | load_use;
      M_bubble = ~m_ok | ~w_ok;
      W_stall  = ~w_ok;
      set_cc   = (E_icode == I_OPQ) & m_ok & w_ok;
    end
  end

  // Run/halt FSM with status latch and wrapping performance counters; all frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cpu_stat  <= STAT_AOK;
      cycle_cnt <= 32'd0;
      instr_cnt <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (state == RUN) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (w_ok && (W_icode != I_NOP))
        instr_cnt <= instr_cnt + 32'd1;
      if (F_stall)
        stall_cnt <= stall_cnt + 32'd1;
      if (!w_ok) begin
        state    <= HALTED;
        cpu_stat <= W_stat;
      end
    end
  end

  assign halted = (state == HALTED);

endmodule
